spi_matrix_host: RTL and testbench
==================================

SPI_MATRIX_HOST -- requirements
Module: spi_matrix_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning the number of clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter WORD_W, default 32, meaning the SPI word width in bits, matching the matrix element width.
REQ-003 SHALL have parameter CNT_W, default 18, meaning the word-count width (covers 784*288 words).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to send one frame.
REQ-007 word_count  in  CNT_W  number of words in the frame; sampled when start is accepted.
REQ-008 tx_data  in  WORD_W  next word to transmit.
REQ-009 tx_valid / tx_ready  in / out  1 each  word handshake; transfer occurs when both are high on a clk edge.
REQ-010 rx_data  out  WORD_W  word captured from miso.
REQ-011 rx_valid  out  1  one-cycle strobe marking rx_data valid.
REQ-012 sclk / mosi / cs_n  out  1 each  SPI master outputs, mode 0.
REQ-013 miso  in  1  SPI slave output.
REQ-014 busy  out  1  high from start acceptance until done.
REQ-015 done  out  1  one-cycle pulse at frame end.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, LOAD, SHIFT, HOLD, FIN.
- IDLE -> SETUP on start with word_count != 0; IDLE -> FIN on start with word_count == 0 (no cs_n activity).
- SETUP: cs_n low for CLK_DIV cycles -> LOAD.
- LOAD: tx_ready high; handshake loads the shift register -> SHIFT. Without tx_valid, the block stays in LOAD with sclk low and cs_n low (stall gap).
- SHIFT: WORD_W bits -> LOAD if words remain, else HOLD.
- HOLD: CLK_DIV cycles with sclk low -> cs_n high -> FIN.
- FIN: done=1 for one cycle -> IDLE.
REQ-017 SHALL transmit MSB first; each bit is a CLK_DIV-cycle sclk-low phase followed by a CLK_DIV-cycle sclk-high phase.
REQ-018 SHALL drive mosi at the start of each low phase and sample miso on the clk edge that raises sclk.
REQ-019 SHALL make one word with tx_valid continuously high occupy exactly 2*CLK_DIV*WORD_W clk cycles in SHIFT.
REQ-020 SHALL assert rx_valid in the cycle after the WORD_W-th miso sample, with rx_data held until the next strobe.
REQ-021 SHALL assert tx_ready only in LOAD, for at most one handshake per word.
REQ-022 SHALL ignore start while busy is high; word_count changes mid-frame SHALL have no effect.
REQ-023 SHALL use a words-remaining counter that decrements per handshake, with no wrap-around; word_count = 2^CNT_W-1 is legal.
REQ-024 SHALL hold sclk low whenever cs_n is high; mosi is don't-care but registered.

Reset
REQ-025 While rst_n=0 the outputs SHALL be: state=IDLE, sclk=0, mosi=0, cs_n=1, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0, counters=0.
REQ-026 Reset asserted mid-frame SHALL immediately raise cs_n and abort the frame with no done pulse.

Structure
REQ-027 Package spi_host_pkg SHALL hold WORD_W, CNT_W defaults and the state enum.
REQ-028 A sub-module spi_half_tick SHALL generate the CLK_DIV half-period tick; it is enabled only in SETUP, SHIFT and HOLD.

Verification
REQ-029 Single word: CLK_DIV=2, word_count=1, tx_data=0xA5A5_0F0F, slave loopback miso=mosi -> 32 sclk pulses, rx_data=0xA5A5_0F0F, done exactly once, cs_n low for 2+128+2 cycles.
REQ-030 Stall: word_count=3 with tx_valid low for 10 cycles before word 2 -> sclk low and cs_n low throughout the gap; 96 total sclk pulses.
REQ-031 Zero length: start with word_count=0 -> cs_n never falls; done pulses 1 cycle after start.
REQ-032 Start while busy: second start mid-frame -> ignored; exactly one done.
REQ-033 Reset mid-frame: rst_n low after bit 10 of word 1 -> cs_n=1 and sclk=0 within the same cycle; no done pulse; a new frame after reset is correct.
REQ-034 Full-duplex miso: slave drives 0x1234_5678 with CLK_DIV=1 -> rx_data=0x1234_5678 and rx_valid strobed once per word.

Source files
------------

// File: rtl/spi_host_pkg.sv
// Shared defaults and FSM state encoding for the SPI matrix host.
package spi_host_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_CNT_W  = 18;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        SHIFT,
        HOLD,
        FIN
    } state_t;

endpackage

// File: rtl/spi_matrix_host_if.sv
// Frame/word handshake plus SPI pins of the matrix host.
// master = the requester issuing frames, slave = the host block itself.
interface spi_matrix_host_if
    import spi_host_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              start;
    logic [CNT_W-1:0]  word_count;
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              miso;
    logic              busy;
    logic              done;

    modport slave (
        input  start, word_count, tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, sclk, mosi, cs_n, busy, done
    );

    modport master (
        output start, word_count, tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, sclk, mosi, cs_n, busy, done
    );

endinterface

// File: rtl/spi_half_tick.sv
// Half-period tick: fires on every CLK_DIV-th enabled cycle, restarts when disabled.
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    logic [7:0] r_cnt;

    assign o_tick = i_en && (r_cnt == 8'(CLK_DIV - 1));

    // Count enabled cycles; a disabled gap always restarts a full half period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_matrix_host.sv
// SPI mode-0 frame master: streams word_count words MSB first, full duplex.
module spi_matrix_host
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst_n,
    spi_matrix_host_if.slave bus
);

    localparam int               BIT_W    = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    state_t            r_state, w_next;
    logic              r_sclk, r_mosi, r_rx_valid;
    logic [WORD_W-1:0] r_tx_sh, r_rx_data;
    logic [WORD_W-2:0] r_rx_sh;
    logic [CNT_W-1:0]  r_remain;
    logic [BIT_W-1:0]  r_bit;
    logic              w_tick, w_tick_en, w_hs, w_word_end;

    assign w_tick_en  = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
    assign w_hs       = (r_state == LOAD) && bus.tx_valid;
    // Falling tick that closes the high phase of the last bit.
    assign w_word_end = (r_state == SHIFT) && w_tick && r_sclk && (r_bit == LAST_BIT);

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    // cs_n, busy and done decode straight from state so reset clears them at once.
    assign bus.cs_n     = !((r_state == SETUP) || (r_state == LOAD) ||
                            (r_state == SHIFT) || (r_state == HOLD));
    assign bus.tx_ready = (r_state == LOAD);
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == FIN);
    assign bus.sclk     = r_sclk;
    assign bus.mosi     = r_mosi;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = (bus.word_count == '0) ? FIN : SETUP;
            SETUP:   if (w_tick) w_next = LOAD;
            LOAD:    if (bus.tx_valid) w_next = SHIFT;
            SHIFT:   if (w_word_end) w_next = (r_remain != '0) ? LOAD : HOLD;
            HOLD:    if (w_tick) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: word load, sclk phases, mosi shift-out, miso capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_sh    <= '0;
            r_tx_sh    <= '0;
            r_remain   <= '0;
            r_bit      <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state == IDLE && bus.start) begin
                r_remain <= bus.word_count;
            end
            if (w_hs) begin
                r_tx_sh  <= bus.tx_data;
                r_mosi   <= bus.tx_data[WORD_W-1];
                r_remain <= r_remain - 1'b1;
                r_bit    <= '0;
            end
            if (r_state == SHIFT && w_tick) begin
                if (!r_sclk) begin
                    // Rising edge of sclk: sample miso on this very clk edge.
                    r_sclk  <= 1'b1;
                    r_rx_sh <= {r_rx_sh[WORD_W-3:0], bus.miso};
                    if (r_bit == LAST_BIT) begin
                        r_rx_data  <= {r_rx_sh, bus.miso};
                        r_rx_valid <= 1'b1;
                    end
                end else begin
                    // Falling edge: present the next bit for the new low phase.
                    r_sclk <= 1'b0;
                    if (r_bit != LAST_BIT) begin
                        r_bit   <= r_bit + 1'b1;
                        r_tx_sh <= r_tx_sh << 1;
                        r_mosi  <= r_tx_sh[WORD_W-2];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_matrix_host.sv
// Directed bench: CLK_DIV=2 instance in mosi->miso loopback, CLK_DIV=1 instance
// against a small mode-0 slave model.
module tb_spi_matrix_host;

    localparam logic [31:0] PAT0 = 32'h1234_5678;
    localparam logic [31:0] PAT1 = 32'hCAFE_F00D;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    spi_matrix_host_if #(.WORD_W(32), .CNT_W(18)) if2 ();
    spi_matrix_host_if #(.WORD_W(32), .CNT_W(18)) if1 ();

    spi_matrix_host #(.CLK_DIV(2), .WORD_W(32), .CNT_W(18)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));
    spi_matrix_host #(.CLK_DIV(1), .WORD_W(32), .CNT_W(18)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    assign if2.miso = if2.mosi;

    // Slave model for dut1: shifts PAT0 then PAT1 out MSB first, advancing on sclk fall.
    int          slv_fall = 0;
    logic [31:0] slv_word;
    logic [4:0]  slv_idx;
    always @(negedge if1.sclk) slv_fall <= slv_fall + 1;
    always_comb begin
        slv_word = (slv_fall < 32) ? PAT0 : PAT1;
        slv_idx  = 5'(31 - (slv_fall % 32));
    end
    assign if1.miso = slv_word[slv_idx];

    // Cumulative monitors sampled on the falling clk edge.
    int          n_sclk2 = 0, n_done2 = 0, n_csl2 = 0, n_rdy2 = 0, n_rxv2 = 0, n_bad2 = 0;
    int          n_sclk1 = 0, n_done1 = 0, n_rxv1 = 0;
    logic        prev_sclk2 = 1'b0, prev_sclk1 = 1'b0;
    logic [31:0] last_rx2 = '0;
    logic [31:0] rx1 [0:3];

    always @(negedge clk) begin
        prev_sclk2 <= if2.sclk;
        if (if2.sclk && !prev_sclk2)   n_sclk2 <= n_sclk2 + 1;
        if (if2.done)                  n_done2 <= n_done2 + 1;
        if (!if2.cs_n && !if2.tx_ready) n_csl2 <= n_csl2 + 1;
        if (if2.tx_ready)              n_rdy2  <= n_rdy2 + 1;
        if (if2.cs_n && if2.sclk)      n_bad2  <= n_bad2 + 1;
        if (if2.rx_valid) begin
            n_rxv2   <= n_rxv2 + 1;
            last_rx2 <= if2.rx_data;
        end
    end

    always @(negedge clk) begin
        prev_sclk1 <= if1.sclk;
        if (if1.sclk && !prev_sclk1) n_sclk1 <= n_sclk1 + 1;
        if (if1.done)                n_done1 <= n_done1 + 1;
        if (if1.rx_valid) begin
            if (n_rxv1 < 4) rx1[n_rxv1] <= if1.rx_data;
            n_rxv1 <= n_rxv1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start2(input logic [17:0] cnt, input logic [31:0] data);
        if2.word_count = cnt;
        if2.tx_data    = data;
        if2.tx_valid   = 1'b1;
        if2.start      = 1'b1;
        tick(1);
        if2.start      = 1'b0;
    endtask

    task automatic wait_done2(input int base, input int max);
        for (int i = 0; i < max; i++) begin
            if (n_done2 != base) break;
            tick(1);
        end
        chk("done2_seen", 64'(n_done2 != base), 64'd1);
    endtask

    int b_sclk, b_done, b_csl, b_rdy, b_rxv, gap_bad;

    initial begin
        rst_n = 1'b0;
        if2.start = 1'b0; if2.word_count = '0; if2.tx_data = '0; if2.tx_valid = 1'b0;
        if1.start = 1'b0; if1.word_count = '0; if1.tx_data = '0; if1.tx_valid = 1'b0;
        tick(3);

        // Reset state
        chk("rst_cs_n",     64'(if2.cs_n),     64'd1);
        chk("rst_sclk",     64'(if2.sclk),     64'd0);
        chk("rst_mosi",     64'(if2.mosi),     64'd0);
        chk("rst_tx_ready", 64'(if2.tx_ready), 64'd0);
        chk("rst_rx_valid", 64'(if2.rx_valid), 64'd0);
        chk("rst_rx_data",  64'(if2.rx_data),  64'd0);
        chk("rst_busy",     64'(if2.busy),     64'd0);
        chk("rst_done",     64'(if2.done),     64'd0);
        rst_n = 1'b1;
        tick(2);

        // Full duplex at CLK_DIV=1, two words from the slave model
        if1.word_count = 18'd2; if1.tx_data = 32'hFFFF_0000; if1.tx_valid = 1'b1;
        if1.start = 1'b1;
        tick(1);
        if1.start = 1'b0;
        for (int i = 0; i < 400 && n_done1 == 0; i++) tick(1);
        tick(3);
        chk("fd_done",   64'(n_done1), 64'd1);
        chk("fd_sclk",   64'(n_sclk1), 64'd64);
        chk("fd_rxv",    64'(n_rxv1),  64'd2);
        chk("fd_rx0",    64'(rx1[0]),  64'(PAT0));
        chk("fd_rx1",    64'(rx1[1]),  64'(PAT1));

        // Single word, loopback
        b_sclk = n_sclk2; b_done = n_done2; b_csl = n_csl2; b_rdy = n_rdy2; b_rxv = n_rxv2;
        start2(18'd1, 32'hA5A5_0F0F);
        wait_done2(b_done, 500);
        tick(5);
        chk("sw_sclk",  64'(n_sclk2 - b_sclk), 64'd32);
        chk("sw_rx",    64'(last_rx2),         64'hA5A5_0F0F);
        chk("sw_done",  64'(n_done2 - b_done), 64'd1);
        // cs_n low through SETUP + SHIFT + HOLD; the LOAD handshake cycle is counted apart
        chk("sw_csl",   64'(n_csl2 - b_csl),   64'd132);
        chk("sw_load",  64'(n_rdy2 - b_rdy),   64'd1);
        chk("sw_rxv",   64'(n_rxv2 - b_rxv),   64'd1);

        // Three words with a 10-cycle stall before word 2
        b_sclk = n_sclk2; b_done = n_done2; b_csl = n_csl2; b_rdy = n_rdy2;
        start2(18'd3, 32'h0F0F_3C3C);
        for (int i = 0; i < 50 && !if2.tx_ready; i++) tick(1);
        tick(1);
        if2.tx_valid = 1'b0;
        if2.tx_data  = 32'h5A5A_C3C3;
        for (int i = 0; i < 400 && !if2.tx_ready; i++) tick(1);
        gap_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (if2.sclk || if2.cs_n || !if2.tx_ready) gap_bad++;
            tick(1);
        end
        chk("stall_gap", 64'(gap_bad), 64'd0);
        if2.tx_valid = 1'b1;
        wait_done2(b_done, 1000);
        tick(5);
        chk("stall_sclk", 64'(n_sclk2 - b_sclk), 64'd96);
        chk("stall_done", 64'(n_done2 - b_done), 64'd1);
        chk("stall_rdy",  64'(n_rdy2 - b_rdy),   64'd13);
        chk("stall_csl",  64'(n_csl2 - b_csl),   64'd388);
        chk("stall_rx",   64'(last_rx2),         64'h5A5A_C3C3);

        // Zero-length frame
        b_done = n_done2; b_csl = n_csl2;
        start2(18'd0, 32'h0);
        chk("zl_done_hi", 64'(if2.done), 64'd1);
        chk("zl_busy_hi", 64'(if2.busy), 64'd1);
        chk("zl_cs_n",    64'(if2.cs_n), 64'd1);
        tick(1);
        chk("zl_done_lo", 64'(if2.done), 64'd0);
        chk("zl_busy_lo", 64'(if2.busy), 64'd0);
        tick(3);
        chk("zl_done_cnt", 64'(n_done2 - b_done), 64'd1);
        chk("zl_csl",      64'(n_csl2 - b_csl),   64'd0);

        // Start (and a new word_count) while busy is ignored
        b_sclk = n_sclk2; b_done = n_done2;
        start2(18'd2, 32'h8000_0001);
        tick(50);
        if2.word_count = 18'd5;
        if2.start = 1'b1;
        tick(1);
        if2.start = 1'b0;
        wait_done2(b_done, 800);
        tick(20);
        chk("sb_done", 64'(n_done2 - b_done), 64'd1);
        chk("sb_sclk", 64'(n_sclk2 - b_sclk), 64'd64);
        chk("sb_busy", 64'(if2.busy),         64'd0);
        chk("sb_rx",   64'(last_rx2),         64'h8000_0001);

        // Reset mid-frame after bit 10, then a clean frame
        b_sclk = n_sclk2; b_done = n_done2;
        start2(18'd1, 32'hFFFF_FFFF);
        for (int i = 0; i < 300 && (n_sclk2 - b_sclk) < 10; i++) tick(1);
        rst_n = 1'b0;
        #1;
        chk("mr_cs_n", 64'(if2.cs_n), 64'd1);
        chk("mr_sclk", 64'(if2.sclk), 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("mr_no_done", 64'(n_done2 - b_done), 64'd0);
        b_sclk = n_sclk2; b_done = n_done2;
        start2(18'd1, 32'h0123_4567);
        wait_done2(b_done, 500);
        tick(5);
        chk("mr_sclk_after", 64'(n_sclk2 - b_sclk), 64'd32);
        chk("mr_rx_after",   64'(last_rx2),         64'h0123_4567);
        chk("mr_done_after", 64'(n_done2 - b_done), 64'd1);

        // sclk never high while cs_n is high, over the whole run
        chk("sclk_idle_low", 64'(n_bad2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
